// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and helpers for the two-port memory arbiter.
//   owner_t  : who drives the memory this cycle (IDLE, OWN0, OWN1)
//   NUM_PORTS: number of requesters
//   pick()   : choose a new owner from the pending flags. When both ports are
//              pending, the port that was not granted last wins.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  localparam int NUM_PORTS = 2;

  function automatic owner_t pick(input logic pend0, input logic pend1,
                                  input logic last);
    owner_t o;
    if (pend0 && pend1)
      o = last ? OWN0 : OWN1;
    else if (pend0)
      o = OWN0;
    else if (pend1)
      o = OWN1;
    else
      o = IDLE;
    return o;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational tie-break for the memory arbiter.
//   Macro ARB_RR_EN: defined   -> round-robin, the port not granted last wins a tie
//                    undefined -> fixed priority, port 0 always wins a tie
// Ports:
//   pend0, pend1 : in  port has a beat waiting for a fresh grant
//   last         : in  port that received the most recent grant (0/1)
//   owner        : out owner selected if no locked burst overrides it
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   pend0,
  input  logic   pend1,
  input  logic   last,
  output owner_t owner
);

`ifdef ARB_RR_EN
  assign owner = pick(pend0, pend1, last);
`else
  // Pinning last to 1 turns the round-robin rule into "port 0 wins ties".
  logic unused_last;
  assign unused_last = last;
  assign owner = pick(pend0, pend1, 1'b1);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a single-port word memory (combinational read, posedge write)
//   between port 0 (ARM core) and port 1 (DMA/debug loader). A registered owner
//   decides which port drives the memory each cycle. Locked bursts keep the
//   owner, but a waiting port gets the memory after at most MAX_BURST locked beats.
//   Tie-break mode is chosen by macro ARB_RR_EN (see mem_arb_pick).
// Parameters: AW address width, DW data width, MAX_BURST locked-beat cap (>=1)
// Ports:
//   clk, reset (async, active-low)
//   reqN/lockN/weN/addrN/wdataN : requester N beat, held until gntN is seen
//   gntN     : beat of port N accepted this cycle (memory driven by port N)
//   rvalidN  : rdata holds the result of port N's read granted last cycle
//   rdata    : registered read data, shared between ports
//   mem_we/mem_a/mem_wd : to memory; mem_rd : from memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int            CW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

  owner_t                 owner, owner_nxt, pick_owner;
  logic                   last;
  logic [CW-1:0]          burst_cnt, cnt_nxt;
  logic [NUM_PORTS-1:0]   pend;

  // A granted unlocked beat is finished; its still-high req must not win again.
  assign pend = {req1 & ~(gnt1 & ~lock1), req0 & ~(gnt0 & ~lock0)};

  mem_arb_pick u_pick (
    .pend0 (pend[0]),
    .pend1 (pend[1]),
    .last  (last),
    .owner (pick_owner)
  );

  always_comb begin
    owner_nxt = pick_owner;
    cnt_nxt   = '0;
    if (owner == OWN0 && lock0 && req0) begin
      if (!pend[1]) begin
        owner_nxt = OWN0;
        cnt_nxt   = burst_cnt;
      end else if (burst_cnt < CAP) begin
        owner_nxt = OWN0;
        cnt_nxt   = burst_cnt + 1'b1;
      end else begin
        owner_nxt = OWN1;
      end
    end else if (owner == OWN1 && lock1 && req1) begin
      if (!pend[0]) begin
        owner_nxt = OWN1;
        cnt_nxt   = burst_cnt;
      end else if (burst_cnt < CAP) begin
        owner_nxt = OWN1;
        cnt_nxt   = burst_cnt + 1'b1;
      end else begin
        owner_nxt = OWN0;
      end
    end else if (pick_owner == owner) begin
      cnt_nxt = burst_cnt;
    end
  end

  // Memory follows the live inputs of the current owner.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    case (owner)
      OWN0: begin
        mem_we = we0;
        mem_a  = addr0;
        mem_wd = wdata0;
      end
      OWN1: begin
        mem_we = we1;
        mem_a  = addr1;
        mem_wd = wdata1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata     <= '0;
      burst_cnt <= '0;
      last      <= 1'b1;
    end else begin
      owner     <= owner_nxt;
      gnt0      <= (owner_nxt == OWN0);
      gnt1      <= (owner_nxt == OWN1);
      burst_cnt <= cnt_nxt;
      rvalid0   <= (owner == OWN0) && !we0;
      rvalid1   <= (owner == OWN1) && !we1;
      if (owner != IDLE)
        last <= (owner == OWN1);
      if ((owner == OWN0 && !we0) || (owner == OWN1 && !we1))
        rdata <= mem_rd;
    end
  end

endmodule
